median_scan_ctrl: RTL

MEDIAN_SCAN_CTRL -- requirements
Module: median_scan_ctrl

---
 rtl/median_pkg.sv | 23 ++
 rtl/median_addr_gen.sv | 43 ++++
 rtl/median_scan_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 median scan controller.
// The interior test is shared by the FSM and the address generator so both agree on border handling.
package median_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN_TAPS = 9;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } state_t;

    // A pixel is interior when its full 3x3 neighbourhood lies inside the image.
    function automatic logic is_interior(input int row, input int col,
                                         input int width, input int height);
        return (row >= 1) && (row <= height - 2) && (col >= 1) && (col <= width - 2);
    endfunction

endpackage

// File: rtl/median_addr_gen.sv
// Maps (row, col, tap) to a source-image word address.
// Interior pixels walk the 3x3 window row-major; border pixels always read the pixel itself.
module median_addr_gen
    import median_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 7,
    parameter int ROW_W  = 3,
    parameter int COL_W  = 3
)(
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    input  logic [3:0]        tap,
    output logic [ADDR_W-1:0] addr
);

    logic [1:0]        tap_row;
    logic [1:0]        tap_col;
    logic [ADDR_W-1:0] eff_row;
    logic [ADDR_W-1:0] eff_col;

    // Out-of-range tap indices fall back to the centre tap so the address stays inside the image.
    always_comb begin
        tap_row = 2'd1;
        tap_col = 2'd1;
        if (tap < 4'd9) begin
            tap_row = 2'(tap / 4'd3);
            tap_col = 2'(tap % 4'd3);
        end

        if (is_interior(int'(row), int'(col), IMG_W, IMG_H)) begin
            eff_row = ADDR_W'(row) + ADDR_W'(tap_row) - ADDR_W'(1);
            eff_col = ADDR_W'(col) + ADDR_W'(tap_col) - ADDR_W'(1);
        end else begin
            eff_row = ADDR_W'(row);
            eff_col = ADDR_W'(col);
        end

        addr = eff_row * ADDR_W'(IMG_W) + eff_col;
    end

endmodule

// File: rtl/median_scan_ctrl.sv
// Row-major scan controller: gathers 3x3 windows for interior pixels, hands them to an
// external median unit, and writes each result (or the untouched border pixel) to the output image.
module median_scan_ctrl
    import median_pkg::*;
#(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int OUT_BASE = 64,
    parameter int ADDR_W   = 7
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [PIX_W-1:0]          rd_data,
    output logic                      win_valid,
    input  logic                      win_ready,
    output logic [WIN_TAPS*PIX_W-1:0] win_data,
    input  logic                      med_valid,
    input  logic [PIX_W-1:0]          med_data,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [PIX_W-1:0]          wr_data
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    state_t                              state;
    logic [ROW_W-1:0]                    row;
    logic [COL_W-1:0]                    col;
    logic [ROW_W-1:0]                    nxt_row;
    logic [COL_W-1:0]                    nxt_col;
    logic [3:0]                          fetch_cnt;
    logic [WIN_TAPS-1:0][PIX_W-1:0]      taps;
    logic                                last_col;
    logic                                last_row;
    logic                                interior;
    logic [ADDR_W-1:0]                   out_addr;
    logic [ROW_W-1:0]                    ag_row;
    logic [COL_W-1:0]                    ag_col;
    logic [3:0]                          ag_tap;
    logic [ADDR_W-1:0]                   ag_addr;

    assign win_data = taps;

    // rd_addr is registered, so the generator is fed the coordinates of the read issued next cycle.
    always_comb begin
        last_col = (col == COL_W'(IMG_W - 1));
        last_row = (row == ROW_W'(IMG_H - 1));
        nxt_col  = last_col ? '0 : col + COL_W'(1);
        nxt_row  = last_col ? row + ROW_W'(1) : row;
        interior = is_interior(int'(row), int'(col), IMG_W, IMG_H);
        out_addr = ADDR_W'(OUT_BASE) + ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);

        ag_row = row;
        ag_col = col;
        ag_tap = '0;
        case (state)
            IDLE: begin
                ag_row = '0;
                ag_col = '0;
            end
            FETCH: ag_tap = fetch_cnt + 4'd1;
            WRITE: begin
                ag_row = nxt_row;
                ag_col = nxt_col;
            end
            default: ;
        endcase
    end

    median_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W)
    ) u_addr_gen (
        .row  (ag_row),
        .col  (ag_col),
        .tap  (ag_tap),
        .addr (ag_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            fetch_cnt <= '0;
            taps      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            win_valid <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row       <= '0;
                        col       <= '0;
                        fetch_cnt <= '0;
                        busy      <= 1'b1;
                        rd_en     <= 1'b1;
                        rd_addr   <= ag_addr;
                        state     <= FETCH;
                    end
                end

                // fetch_cnt counts FETCH cycles; data for tap k arrives while fetch_cnt == k+1.
                FETCH: begin
                    fetch_cnt <= fetch_cnt + 4'd1;
                    for (int i = 0; i < WIN_TAPS; i++) begin
                        if (fetch_cnt == 4'(i + 1)) begin
                            taps[i] <= rd_data;
                        end
                    end
                    if (!interior) begin
                        rd_en <= 1'b0;
                        if (fetch_cnt == 4'd1) begin
                            wr_en   <= 1'b1;
                            wr_addr <= out_addr;
                            wr_data <= rd_data;
                            state   <= WRITE;
                        end
                    end else begin
                        rd_en <= (fetch_cnt < 4'd8);
                        if (fetch_cnt < 4'd8) begin
                            rd_addr <= ag_addr;
                        end
                        if (fetch_cnt == 4'd9) begin
                            win_valid <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        state     <= WAIT;
                    end
                end

                WAIT: begin
                    if (med_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= out_addr;
                        wr_data <= med_data;
                        state   <= WRITE;
                    end
                end

                WRITE: begin
                    wr_en <= 1'b0;
                    col   <= nxt_col;
                    row   <= nxt_row;
                    if (last_col && last_row) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        fetch_cnt <= '0;
                        rd_en     <= 1'b1;
                        rd_addr   <= ag_addr;
                        state     <= FETCH;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
